outport_rr_queue: RTL and testbench

- Output-port stage of the 8x8 switch, one instance per output port.
- Directly consumes the per-destination payload lanes produced by the eight input-side demux stages.
- Collects the 32-bit words from all eight inputs, arbitrates round-robin between contending inputs, and queues winners in a small show-ahead FIFO.
- Drives one serialized payload stream with a valid/ready handshake towards the output mux/port.

---
 rtl/outport_rr_queue.sv | 129 ++++++++++++
 tb/tb_outport_rr_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/outport_rr_queue.sv
// Output-port stage of the 8x8 switch: round-robin arbitration across input lanes feeding a show-ahead FIFO.
// Optional statistics counters (word_count, stall_count) are built when OUTPORT_STATS_EN is defined.
module outport_rr_queue #(
    parameter int DATA_W     = 32,
    parameter int NUM_IN     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_IN-1:0]             req_in,
    input  logic [NUM_IN*DATA_W-1:0]      payload_in,
    output logic [NUM_IN-1:0]             grant_out,
    output logic [DATA_W-1:0]             payload_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef OUTPORT_STATS_EN
    ,
    output logic [15:0]                   word_count,
    output logic [15:0]                   stall_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SEL_W = $clog2(NUM_IN);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    function automatic logic [SEL_W-1:0] next_lane(input logic [SEL_W-1:0] lane);
        return (lane == SEL_W'(NUM_IN - 1)) ? '0 : lane + 1'b1;
    endfunction

`ifdef OUTPORT_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [SEL_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              rd_en;
    logic              grant_vld;
    logic [SEL_W-1:0]  grant_idx;
    logic [NUM_IN-1:0] grant;
    logic [DATA_W-1:0] wr_data;

    assign full  = (count == FULL_CNT);
    assign rd_en = valid_out && ready_in;

    // Scan lanes starting at rr_ptr; the first requester wins. Held off while full or in reset.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        if (rst_n && !full) begin
            for (int k = 0; k < NUM_IN; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_IN) begin
                    idx = idx - NUM_IN;
                end
                if (!grant_vld && req_in[idx[SEL_W-1:0]]) begin
                    grant_vld                  = 1'b1;
                    grant_idx                  = idx[SEL_W-1:0];
                    grant[idx[SEL_W-1:0]]      = 1'b1;
                end
            end
        end
    end

    // Only the granted (hence requesting) lane is ever selected into storage.
    assign wr_data   = payload_in[grant_idx*DATA_W +: DATA_W];
    assign grant_out = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (grant_vld) begin
                rr_ptr <= next_lane(grant_idx);
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({grant_vld, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (grant_vld) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign valid_out   = (count != '0);
    assign payload_out = valid_out ? mem[rd_ptr] : '0;
    assign fifo_count  = count;

`ifdef OUTPORT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count  <= '0;
            stall_count <= '0;
        end else begin
            if (grant_vld) begin
                word_count <= sat_inc16(word_count);
            end
            if ((|req_in) && full) begin
                stall_count <= sat_inc16(stall_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_outport_rr_queue.sv
// Self-checking bench for outport_rr_queue: directed vector table, mid-operation reset, and a random phase
// scored against a queue model of the arbiter and FIFO.
module tb_outport_rr_queue;

    localparam int DATA_W     = 32;
    localparam int NUM_IN     = 8;
    localparam int FIFO_DEPTH = 4;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NUM_IN-1:0]           req_in;
    logic [NUM_IN*DATA_W-1:0]    payload_in;
    logic [NUM_IN-1:0]           grant_out;
    logic [DATA_W-1:0]           payload_out;
    logic                        valid_out;
    logic                        ready_in;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
`ifdef OUTPORT_STATS_EN
    logic [15:0]                 word_count;
    logic [15:0]                 stall_count;
    int                          mword;
    int                          mstall;
`endif

    always #5 clk = ~clk;

    outport_rr_queue #(
        .DATA_W(DATA_W), .NUM_IN(NUM_IN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_in(req_in),
        .payload_in(payload_in),
        .grant_out(grant_out),
        .payload_out(payload_out),
        .valid_out(valid_out),
        .ready_in(ready_in),
        .fifo_count(fifo_count)
`ifdef OUTPORT_STATS_EN
        ,
        .word_count(word_count),
        .stall_count(stall_count)
`endif
    );

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic [7:0] exp_g;
        int         exp_cnt;
    } vec_t;

    vec_t        tbl [23];
    logic [31:0] q [$];
    logic [31:0] lane_word [NUM_IN];
    int          mrr;
    int          seq;
    int          tests;
    int          failed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_grant(input logic [7:0] req);
        int idx;
        if (q.size() >= FIFO_DEPTH || req == 8'h00) return 8'h00;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = (mrr + k) % NUM_IN;
            if (req[idx]) return 8'h01 << idx;
        end
        return 8'h00;
    endfunction

    task automatic drive(input logic [7:0] req, input logic rdy);
        req_in   = req;
        ready_in = rdy;
        for (int i = 0; i < NUM_IN; i++) begin
            payload_in[i*DATA_W +: DATA_W] = req[i] ? lane_word[i] : 32'hxxxxxxxx;
        end
    endtask

    // Drive one cycle, check outputs before the edge, clock, then advance the model.
    task automatic step(input logic [7:0] req, input logic rdy, input bit use_exp,
                        input logic [7:0] exp_g, input int exp_cnt);
        logic [7:0] mg;
        bit         rd;
        drive(req, rdy);
        #1;
        mg = model_grant(req);
        check("grant", 32'(grant_out), use_exp ? 32'(exp_g) : 32'(mg));
        check("count", 32'(fifo_count), use_exp ? 32'(exp_cnt) : 32'(q.size()));
        check("valid", 32'(valid_out), 32'(q.size() != 0));
        check("payload", payload_out, (q.size() != 0) ? q[0] : 32'h0);
`ifdef OUTPORT_STATS_EN
        check("word_count", 32'(word_count), 32'(mword));
        check("stall_count", 32'(stall_count), 32'(mstall));
`endif
        @(posedge clk);
        rd = (q.size() != 0) && rdy;
`ifdef OUTPORT_STATS_EN
        if (mg != 8'h00 && mword < 65535) mword++;
        if (req != 8'h00 && q.size() == FIFO_DEPTH && mstall < 65535) mstall++;
`endif
        if (rd) void'(q.pop_front());
        if (mg != 8'h00) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (mg[i]) begin
                    q.push_back(lane_word[i]);
                    seq++;
                    lane_word[i] = {4'hA, 4'(i), 24'(seq)};
                    mrr = (i + 1) % NUM_IN;
                end
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failed=%0d", failed);
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; failed = 0; seq = 0; mrr = 0;
`ifdef OUTPORT_STATS_EN
        mword = 0; mstall = 0;
`endif
        for (int i = 0; i < NUM_IN; i++) lane_word[i] = {4'h5, 4'(i), 24'h000100};

        // Round robin with all lanes requesting and reads every cycle
        tbl[0]  = '{8'hFF, 1'b1, 8'h01, 0};
        tbl[1]  = '{8'hFF, 1'b1, 8'h02, 1};
        tbl[2]  = '{8'hFF, 1'b1, 8'h04, 1};
        tbl[3]  = '{8'hFF, 1'b1, 8'h08, 1};
        tbl[4]  = '{8'hFF, 1'b1, 8'h10, 1};
        tbl[5]  = '{8'hFF, 1'b1, 8'h20, 1};
        tbl[6]  = '{8'hFF, 1'b1, 8'h40, 1};
        tbl[7]  = '{8'hFF, 1'b1, 8'h80, 1};
        tbl[8]  = '{8'hFF, 1'b1, 8'h01, 1};
        tbl[9]  = '{8'h00, 1'b1, 8'h00, 1};
        tbl[10] = '{8'h00, 1'b1, 8'h00, 0};
        // Single lane 3
        tbl[11] = '{8'h08, 1'b1, 8'h08, 0};
        tbl[12] = '{8'h00, 1'b1, 8'h00, 1};
        tbl[13] = '{8'h00, 1'b1, 8'h00, 0};
        // Fill with lanes 0 and 2 (rr_ptr starts at 4), then stay full
        tbl[14] = '{8'h05, 1'b0, 8'h01, 0};
        tbl[15] = '{8'h05, 1'b0, 8'h04, 1};
        tbl[16] = '{8'h05, 1'b0, 8'h01, 2};
        tbl[17] = '{8'h05, 1'b0, 8'h04, 3};
        tbl[18] = '{8'h05, 1'b0, 8'h00, 4};
        tbl[19] = '{8'h05, 1'b0, 8'h00, 4};
        // Read while full: no write-through, then lane 0 follows last winner lane 2
        tbl[20] = '{8'h05, 1'b1, 8'h00, 4};
        tbl[21] = '{8'h05, 1'b0, 8'h01, 3};
        tbl[22] = '{8'h00, 1'b1, 8'h00, 4};

        rst_n = 1'b0;
        drive(8'hFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant_out), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_payload", payload_out, 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        rst_n = 1'b1;
        #1;
        check("first_grant", 32'(grant_out), 32'h01);

        for (int i = 0; i < 23; i++) begin
            if (i == 11) lane_word[3] = 32'hDEADBEEF;
            step(tbl[i].req, tbl[i].rdy, 1'b1, tbl[i].exp_g, tbl[i].exp_cnt);
            if (i == 11) begin
                check("single_valid", 32'(valid_out), 32'h1);
                check("single_payload", payload_out, 32'hDEADBEEF);
            end
        end

        // Asynchronous reset between edges with three words queued
        #2;
        drive(8'hFF, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(valid_out), 32'h0);
        check("midrst_count", 32'(fifo_count), 32'h0);
        check("midrst_payload", payload_out, 32'h0);
        check("midrst_grant", 32'(grant_out), 32'h0);
`ifdef OUTPORT_STATS_EN
        check("midrst_words", 32'(word_count), 32'h0);
        mword = 0; mstall = 0;
`endif
        q.delete();
        mrr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h00, 1'b1, 1'b1, 8'h00, 0);
        step(8'h20, 1'b1, 1'b1, 8'h20, 0);
        step(8'h00, 1'b1, 1'b1, 8'h00, 1);
        step(8'h00, 1'b1, 1'b1, 8'h00, 0);

        // Random traffic, first biased towards a full queue, then towards draining
        for (int i = 0; i < 120; i++) begin
            logic [7:0] r;
            logic       rd;
            r  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) r = 8'h00;
            rd = (i < 60) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            step(r, rd, 1'b0, 8'h00, 0);
        end
        for (int i = 0; i < 6; i++) step(8'h00, 1'b1, 1'b0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
